icw_ocw_sequencer: RTL and testbench
====================================

// Module: icw_ocw_sequencer
// PURPOSE
//  Bus-side front end of the 8259 PIC, directly upstream of the control logic.
//  Samples the CPU write strobes (cs_n, wr_n, a0, datain) and runs the ICW1..ICW4 init sequence.
//  Classifies each completed write and emits one-cycle one-hot ICWs/OCWs strobes plus the latched
//  data_out byte, which feed the control logic's ICWs/OCWs/datain inputs.
//  Also qualifies reads (rd_en, rd_a0) for the status read-out path.
// PARAMETERS
//  SYNC_EN  1  1: 2-flop synchronizers on cs_n/wr_n/rd_n/a0, datain delayed to match; 0: single register stage
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  rst          in   1  synchronous reset, active-high
//  cs_n         in   1  chip select, active-low
//  wr_n         in   1  write strobe, active-low; command commits on its rising edge
//  rd_n         in   1  read strobe, active-low
//  a0           in   1  register address bit
//  datain       in   8  CPU data bus
//  ICWs         out  4  [4:1] one-hot ICW strobe, high exactly one clk
//  OCWs         out  4  [4:1] one-hot OCW strobe, high exactly one clk; bit 4 always 0
//  data_out     out  8  byte of the last committed command, held until the next commit
//  init_done    out  1  high in READY state
//  single_mode  out  1  SNGL bit (ICW1[1]) of the last ICW1
//  icw4_needed  out  1  IC4 bit (ICW1[0]) of the last ICW1
//  rd_en        out  1  qualified read: synced ~cs_n & ~rd_n & wr_n
//  rd_a0        out  1  synced a0 while rd_en is high, else 0
//  cmd_error    out  1  one-clk pulse for a rejected write or an rd/wr clash
// BEHAVIOUR
//  - Reset values: ICWs=0, OCWs=0, data_out=0, init_done=0, single_mode=0, icw4_needed=0,
//    rd_en=0, rd_a0=0, cmd_error=0; state=IDLE.
//  - Reset mid-sequence aborts it; a write in progress is discarded.
//  - Commit: synced wr_n is 0 in cycle t-1 with synced cs_n also 0 in t-1, and synced wr_n is 1 in cycle t.
//    Byte used = datain sampled in cycle t-1 (last low cycle).
//    If cs_n is high in t-1, nothing is committed and no error is flagged.
//  - Latency: let k be the first clk edge that samples raw wr_n=1.
//    Strobe, data_out and state update are visible after edge k+1 (SYNC_EN=0) or k+3 (SYNC_EN=1).
//  - ICWs and OCWs are never both non-zero. data_out updates in the same cycle as the strobe.
//  - FSM states: IDLE, W_ICW2, W_ICW3, W_ICW4, READY. Decode uses a0, d4, d3.
//  - ICW1 (a0=0, d4=1), accepted in any state: ICWs=0001; latch single_mode=d[1], icw4_needed=d[0];
//    init_done drops; next state W_ICW2.
//  - W_ICW2, a0=1: ICWs=0010. Next: W_ICW3 if !single_mode, else W_ICW4 if icw4_needed, else READY.
//  - W_ICW3, a0=1: ICWs=0100. Next: W_ICW4 if icw4_needed, else READY.
//  - W_ICW4, a0=1: ICWs=1000. Next: READY.
//  - READY, a0=1: OCWs=0001 (OCW1).
//  - READY, a0=0, d4=0, d3=0: OCWs=0010 (OCW2).
//  - READY, a0=0, d4=0, d3=1: OCWs=0100 (OCW3).
//  - Rejected writes: a0=1 in IDLE, or a0=0/d4=0 in IDLE/W_*.
//    Effect: cmd_error pulse, no strobe, no state change, data_out unchanged.
//  - rd/wr clash (cs_n, rd_n and wr_n all low in the same synced cycle): rd_en=0, cmd_error pulses once
//    per clash entry, and the write still commits normally on the wr_n rise.
//  - Back-to-back writes: each wr_n rise yields its own strobe.
//    A new commit in the cycle right after a strobe is legal (strobes adjacent, distinct).
// TESTING
//  1 SYNC_EN=1 init: ICW1=0x13, ICW2=0x40, ICW4=0x03
//    -> ICWs 0001,0010,1000 in turn, no ICW3, init_done=1, data_out=0x03.
//  2 Cascade: ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x01
//    -> ICWs 0001,0010,0100,1000; single_mode=0.
//  3 ICW1=0x12 (no IC4, single) then ICW2=0x20 -> READY after ICW2 (no ICW3/ICW4).
//    Then: a0=1 0xFB -> OCWs=0001, data_out=0xFB; a0=0 0x20 -> OCWs=0010; a0=0 0x0A -> OCWs=0100.
//  4 a0=1 write from IDLE -> cmd_error 1 clk, no strobe.
//    ICW1 issued in W_ICW3 -> restarts at W_ICW2.
//  5 Write with cs_n raised before wr_n rise -> no strobe, no error.
//    rst asserted in W_ICW2 -> all outputs 0, IDLE.
//  6 cs_n=0, rd_n=0, a0=1 -> rd_en=1, rd_a0=1 after 2 clks (SYNC_EN=1).
//    rd_n+wr_n low together -> rd_en=0, one cmd_error pulse.

Source files
------------

// File: rtl/icw_ocw_sequencer.sv
// 8259 bus front end: samples CPU writes, runs the ICW1..ICW4 init
// sequence and classifies committed bytes into ICW/OCW strobes.
module icw_ocw_sequencer #(
  parameter bit SYNC_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       a0,
  input  logic [7:0] datain,
  output logic [3:0] ICWs,
  output logic [3:0] OCWs,
  output logic [7:0] data_out,
  output logic       init_done,
  output logic       single_mode,
  output logic       icw4_needed,
  output logic       rd_en,
  output logic       rd_a0,
  output logic       cmd_error
);

  // W: tap where the write edge is judged (stage W+1 holds the
  // last-low cycle); R: tap of the 2-flop synchronizer for reads.
  localparam int W = SYNC_EN ? 2 : 0;
  localparam int R = SYNC_EN ? 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    READY
  } state_t;

  state_t state, state_n;

  logic [W+1:0] cs_p;
  logic [W+1:0] wr_p;
  logic [W+1:0] a0_p;
  logic [R:0]   rd_p;
  logic [7:0]   d_p [W+1:0];

  logic       commit;
  logic       cmd_a0;
  logic [7:0] cmd_d;
  logic       is_icw1;
  logic [3:0] icw_n;
  logic [3:0] ocw_n;
  logic       rej;
  logic       clash;
  logic       clash_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_p <= '1;
      wr_p <= '1;
      a0_p <= '0;
      rd_p <= '1;
      for (int i = 0; i <= W + 1; i++) d_p[i] <= '0;
    end else begin
      cs_p <= {cs_p[W:0], cs_n};
      wr_p <= {wr_p[W:0], wr_n};
      a0_p <= {a0_p[W:0], a0};
      rd_p[0] <= rd_n;
      for (int i = 1; i <= R; i++) rd_p[i] <= rd_p[i-1];
      d_p[0] <= datain;
      for (int i = 1; i <= W + 1; i++) d_p[i] <= d_p[i-1];
    end
  end

  assign commit  = ~wr_p[W+1] & ~cs_p[W+1] & wr_p[W];
  assign cmd_a0  = a0_p[W+1];
  assign cmd_d   = d_p[W+1];
  assign is_icw1 = ~cmd_a0 & cmd_d[4];

  assign rd_en = ~cs_p[R] & ~rd_p[R] & wr_p[R];
  assign rd_a0 = rd_en & a0_p[R];
  assign clash = ~cs_p[R] & ~rd_p[R] & ~wr_p[R];

  always_comb begin
    state_n = state;
    icw_n   = '0;
    ocw_n   = '0;
    rej     = 1'b0;
    if (commit) begin
      unique case (1'b1)
        is_icw1: begin
          icw_n   = 4'b0001;
          state_n = W_ICW2;
        end
        default: begin
          unique case (state)
            W_ICW2: begin
              if (cmd_a0) begin
                icw_n = 4'b0010;
                if (!single_mode)    state_n = W_ICW3;
                else if (icw4_needed) state_n = W_ICW4;
                else                 state_n = READY;
              end else begin
                rej = 1'b1;
              end
            end
            W_ICW3: begin
              if (cmd_a0) begin
                icw_n   = 4'b0100;
                state_n = icw4_needed ? W_ICW4 : READY;
              end else begin
                rej = 1'b1;
              end
            end
            W_ICW4: begin
              if (cmd_a0) begin
                icw_n   = 4'b1000;
                state_n = READY;
              end else begin
                rej = 1'b1;
              end
            end
            READY: begin
              if (cmd_a0)        ocw_n = 4'b0001;
              else if (cmd_d[3]) ocw_n = 4'b0100;
              else               ocw_n = 4'b0010;
            end
            default: rej = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ICWs        <= '0;
      OCWs        <= '0;
      data_out    <= '0;
      single_mode <= 1'b0;
      icw4_needed <= 1'b0;
      cmd_error   <= 1'b0;
      clash_q     <= 1'b0;
    end else begin
      state     <= state_n;
      ICWs      <= icw_n;
      OCWs      <= ocw_n;
      cmd_error <= rej | (clash & ~clash_q);
      clash_q   <= clash;
      if (|{icw_n, ocw_n}) data_out <= cmd_d;
      if (commit && is_icw1) begin
        single_mode <= cmd_d[1];
        icw4_needed <= cmd_d[0];
      end
    end
  end

  assign init_done = (state == READY);

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed + random bench for icw_ocw_sequencer (SYNC_EN=1), checked
// against a queue-based model of the remaining init words.
module tb_icw_ocw_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] datain = 8'h00;
  logic [3:0] ICWs;
  logic [3:0] OCWs;
  logic [7:0] data_out;
  logic       init_done;
  logic       single_mode;
  logic       icw4_needed;
  logic       rd_en;
  logic       rd_a0;
  logic       cmd_error;

  int checks = 0;
  int failures = 0;

  bit         m_ready;
  bit         m_sngl;
  bit         m_ic4;
  logic [7:0] m_data;
  int         m_q[$];

  icw_ocw_sequencer #(.SYNC_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .cs_n(cs_n),
    .wr_n(wr_n),
    .rd_n(rd_n),
    .a0(a0),
    .datain(datain),
    .ICWs(ICWs),
    .OCWs(OCWs),
    .data_out(data_out),
    .init_done(init_done),
    .single_mode(single_mode),
    .icw4_needed(icw4_needed),
    .rd_en(rd_en),
    .rd_a0(rd_a0),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_sngl  = 1'b0;
    m_ic4   = 1'b0;
    m_data  = 8'h00;
    m_q.delete();
  endtask

  // m_q lists the ICW numbers still owed after ICW1.
  task automatic predict(input logic a0v, input logic [7:0] dv,
                         output logic [3:0] icw,
                         output logic [3:0] ocw,
                         output logic err);
    int n;
    icw = 4'd0;
    ocw = 4'd0;
    err = 1'b0;
    if (!a0v && dv[4]) begin
      icw     = 4'b0001;
      m_sngl  = dv[1];
      m_ic4   = dv[0];
      m_ready = 1'b0;
      m_q     = {2};
      if (!m_sngl) m_q.push_back(3);
      if (m_ic4)   m_q.push_back(4);
      m_data  = dv;
    end else if (m_ready) begin
      if (a0v)        ocw = 4'b0001;
      else if (dv[3]) ocw = 4'b0100;
      else            ocw = 4'b0010;
      m_data = dv;
    end else if (a0v && m_q.size() > 0) begin
      n   = m_q.pop_front();
      icw = 4'(1 << (n - 1));
      if (m_q.size() == 0) m_ready = 1'b1;
      m_data = dv;
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst  = 1'b1;
    cs_n = 1'b1;
    wr_n = 1'b1;
    rd_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_icws", 8'(ICWs), 8'd0);
    chk("rst_ocws", 8'(OCWs), 8'd0);
    chk("rst_data", data_out, 8'd0);
    chk("rst_init", 8'(init_done), 8'd0);
    chk("rst_sngl", 8'(single_mode), 8'd0);
    chk("rst_ic4", 8'(icw4_needed), 8'd0);
    chk("rst_rden", 8'(rd_en), 8'd0);
    chk("rst_rda0", 8'(rd_a0), 8'd0);
    chk("rst_err", 8'(cmd_error), 8'd0);
    rst = 1'b0;
    model_reset();
    repeat (4) @(posedge clk);
  endtask

  task automatic wr_cmd(input logic a0v, input logic [7:0] dv,
                        input bit abort, input bit clash);
    logic [3:0] ei;
    logic [3:0] eo;
    logic       ee;
    @(posedge clk); #1;
    cs_n   = 1'b0;
    a0     = a0v;
    datain = dv;
    wr_n   = 1'b0;
    rd_n   = ~clash;
    repeat (2) @(posedge clk); #1;
    if (clash) chk("clash_rd_en", 8'(rd_en), 8'd0);
    @(posedge clk); #1;
    chk("clash_err", 8'(cmd_error), 8'(clash));
    @(posedge clk); #1;
    chk("err_once", 8'(cmd_error), 8'd0);
    if (abort) begin
      cs_n = 1'b1;
      repeat (4) @(posedge clk); #1;
    end
    wr_n = 1'b1;
    rd_n = 1'b1;
    if (abort) begin
      ei = 4'd0;
      eo = 4'd0;
      ee = 1'b0;
    end else begin
      predict(a0v, dv, ei, eo, ee);
    end
    repeat (3) @(posedge clk); #1;
    chk("pre_strobe", {ICWs, OCWs}, 8'd0);
    @(posedge clk); #1;
    chk("icws", 8'(ICWs), 8'(ei));
    chk("ocws", 8'(OCWs), 8'(eo));
    chk("cmd_err", 8'(cmd_error), 8'(ee));
    chk("data_out", data_out, m_data);
    chk("init_done", 8'(init_done), 8'(m_ready));
    chk("single", 8'(single_mode), 8'(m_sngl));
    chk("icw4_need", 8'(icw4_needed), 8'(m_ic4));
    @(posedge clk); #1;
    chk("post_strobe", {ICWs, OCWs}, 8'd0);
    chk("post_err", 8'(cmd_error), 8'd0);
    cs_n = 1'b1;
  endtask

  initial begin
    logic       ra0;
    logic [7:0] rd;
    int         sel;
    model_reset();
    do_reset();

    wr_cmd(1'b0, 8'h13, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h40, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h03, 1'b0, 1'b0);
    chk("t1_ready", 8'(init_done), 8'd1);
    chk("t1_data", data_out, 8'h03);

    wr_cmd(1'b0, 8'h11, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h08, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h04, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h01, 1'b0, 1'b0);
    chk("t2_sngl", 8'(single_mode), 8'd0);

    wr_cmd(1'b0, 8'h12, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h20, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'hFB, 1'b0, 1'b0);
    chk("t3_ocw1_data", data_out, 8'hFB);
    wr_cmd(1'b0, 8'h20, 1'b0, 1'b0);
    wr_cmd(1'b0, 8'h0A, 1'b0, 1'b0);

    wr_cmd(1'b0, 8'h13, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h5A, 1'b1, 1'b0);
    do_reset();

    wr_cmd(1'b1, 8'h77, 1'b0, 1'b0);
    wr_cmd(1'b0, 8'h11, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h08, 1'b0, 1'b0);
    wr_cmd(1'b0, 8'h11, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h10, 1'b0, 1'b0);

    @(posedge clk); #1;
    cs_n = 1'b0;
    rd_n = 1'b0;
    a0   = 1'b1;
    @(posedge clk); #1;
    chk("rd_lat", 8'(rd_en), 8'd0);
    @(posedge clk); #1;
    chk("rd_en", 8'(rd_en), 8'd1);
    chk("rd_a0", 8'(rd_a0), 8'd1);
    cs_n = 1'b1;
    rd_n = 1'b1;
    a0   = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rd_off", 8'(rd_en), 8'd0);
    chk("rd_a0_off", 8'(rd_a0), 8'd0);

    wr_cmd(1'b0, 8'h12, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h20, 1'b0, 1'b0);
    wr_cmd(1'b1, 8'h55, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra0 = 1'($urandom_range(0, 1));
      rd  = 8'($urandom);
      sel = $urandom_range(0, 7);
      if (sel < 2) begin
        ra0   = 1'b0;
        rd[4] = 1'b1;
      end
      wr_cmd(ra0, rd, sel == 2, sel == 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
